intgrant: RTL

INTGRANT -- requirements
Module: intgrant

---
 rtl/intgrant.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/intgrant.sv
`default_nettype none
// ============================================================================
// Module   : intgrant
// Brief    : Unibus-style interrupt requester for four local devices.
//            Picks the highest-level pending device, arbitrates for the bus
//            with BR/BG/SACK/BBSY, presents the vector with INTR and reports
//            acceptance to the device side with a one-cycle intgnt pulse.
// Revision : 1.0 - initial release
// ============================================================================
module intgrant #(
    parameter int TOCLKS = 1024,
    parameter int DESKEW = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [3:0]  dev_intreq,
    input  logic [31:0] dev_irvec,
    input  logic [7:0]  dev_level,
    output logic        intgnt,
    output logic [7:0]  igvec,
    output logic [3:0]  bus_br_out,
    input  logic [3:0]  bus_bg_in,
    output logic [3:0]  bus_bg_out,
    output logic        bus_sack_out,
    output logic        bus_bbsy_out,
    output logic        bus_intr_out,
    input  logic        bus_bbsy_in,
    input  logic        bus_ssyn_in,
    output logic [7:0]  bus_d_out
);

    localparam int c_TW = $clog2(TOCLKS + 1);
    localparam int c_DW = $clog2(DESKEW + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_SACK    = 3'd2,
        S_WAITBUS = 3'd3,
        S_INTR    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_idx;
    logic [1:0]        r_lvl;
    logic [7:0]        r_vec;
    logic [c_DW-1:0]   r_dcnt;
    logic [c_TW-1:0]   r_tmr;
    logic              r_pulsed;

    logic              w_sel_found;
    logic [1:0]        w_sel_idx;
    logic [1:0]        w_sel_lvl;
    logic [7:0]        w_sel_vec;
    logic              w_req_live;
    logic [3:0]        w_lvl_mask;
    logic              w_bus_quiet;
    logic              w_deskew_done;
    logic              w_timeout;

    logic              w_gnt;
    logic [7:0]        w_gvec;
    logic [3:0]        w_br;
    logic [3:0]        w_bg_block;
    logic              w_sack;
    logic              w_bbsy;
    logic              w_intr;
    logic [7:0]        w_d;

    // Pick the requesting device with the highest level; a strict compare
    // keeps the lowest index on ties.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 2'd0;
        w_sel_lvl   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (dev_intreq[i] && (!w_sel_found || (dev_level[2*i +: 2] > w_sel_lvl))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = 2'(i);
                w_sel_lvl   = dev_level[2*i +: 2];
            end
        end
    end

    assign w_sel_vec     = dev_irvec[{w_sel_idx, 3'b000} +: 8];
    assign w_req_live    = dev_intreq[r_idx];
    assign w_lvl_mask    = 4'b0001 << r_lvl;
    assign w_bus_quiet   = !bus_bbsy_in && !bus_ssyn_in;
    assign w_deskew_done = w_bus_quiet && (r_dcnt == c_DW'(DESKEW - 1));
    assign w_timeout     = (r_tmr == c_TW'(TOCLKS - 1));

    // Transaction sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_sel_found) w_next = S_REQ;
            S_REQ: begin
                // A withdrawn request wins over a simultaneous grant so the
                // grant is passed down instead of taken.
                if (!w_req_live)              w_next = S_IDLE;
                else if (bus_bg_in[r_lvl])    w_next = S_SACK;
            end
            S_SACK:    if (w_deskew_done) w_next = S_WAITBUS;
            S_WAITBUS: w_next = S_INTR;
            S_INTR: begin
                if (bus_ssyn_in)     w_next = S_DONE;
                else if (w_timeout)  w_next = S_IDLE;
            end
            S_DONE:    if (!bus_ssyn_in) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register, latched selection, deskew and timeout counters.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_lvl    <= 2'd0;
            r_vec    <= 8'd0;
            r_dcnt   <= '0;
            r_tmr    <= '0;
            r_pulsed <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pulsed <= (r_state == S_DONE);
            if (r_state == S_IDLE && w_sel_found) begin
                r_idx <= w_sel_idx;
                r_lvl <= w_sel_lvl;
                r_vec <= w_sel_vec;
            end
            if (r_state == S_SACK && w_bus_quiet)
                r_dcnt <= r_dcnt + c_DW'(1);
            else
                r_dcnt <= '0;
            if (r_state == S_INTR)
                r_tmr <= r_tmr + c_TW'(1);
            else
                r_tmr <= '0;
        end
    end

    // Bus and device-side outputs; everything is forced idle while in reset.
    always_comb begin
        w_gnt      = 1'b0;
        w_gvec     = 8'd0;
        w_br       = 4'd0;
        w_bg_block = 4'd0;
        w_sack     = 1'b0;
        w_bbsy     = 1'b0;
        w_intr     = 1'b0;
        w_d        = 8'd0;
        if (!RESET) begin
            case (r_state)
                S_REQ: begin
                    if (w_req_live) begin
                        w_br       = w_lvl_mask;
                        w_bg_block = w_lvl_mask;
                    end
                end
                S_SACK: begin
                    w_sack     = 1'b1;
                    w_bg_block = w_lvl_mask;
                end
                S_WAITBUS: begin
                    w_sack = 1'b1;
                    w_bbsy = 1'b1;
                end
                S_INTR: begin
                    w_bbsy = 1'b1;
                    w_intr = 1'b1;
                    w_d    = r_vec;
                end
                S_DONE: begin
                    w_gnt  = !r_pulsed;
                    w_gvec = r_pulsed ? 8'd0 : r_vec;
                end
                default: ;
            endcase
        end
    end

    assign intgnt       = w_gnt;
    assign igvec        = w_gvec;
    assign bus_br_out   = w_br;
    assign bus_bg_out   = bus_bg_in & ~w_bg_block;
    assign bus_sack_out = w_sack;
    assign bus_bbsy_out = w_bbsy;
    assign bus_intr_out = w_intr;
    assign bus_d_out    = w_d;

endmodule
`default_nettype wire
